// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM sequencing the multicycle MIPS datapath
module mips_multicycle_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] state_o,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3,
    MEM_WB = 4'd4, MEM_WR = 4'd5, EXEC_R = 4'd6, R_WB = 4'd7,
    EXEC_I = 4'd8, I_WB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ORI = 6'b001101,
                         OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_BNE = 6'b000101, OP_J = 6'b000010;
  state_t state, next;
  logic rdy, mw, iw, pw, rw, dn, il;
  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
  always_ff @(posedge clk)
    state <= !reset ? FETCH : next;
  always_comb begin
    next = FETCH;
    alu_op = 3'b000;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mw = 1'b0;
    iw = 1'b0;
    pw = 1'b0;
    pc_source = 2'b00;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    rw = 1'b0;
    dn = 1'b0;
    il = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        alu_op = 3'b100;
        iw = rdy;
        pw = rdy;
        next = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op = 3'b100;
        case (opcode)
          OP_R:           next = EXEC_R;
          OP_ADDI, OP_ORI: next = EXEC_I;
          OP_LW, OP_SW:   next = MEM_ADDR;
          OP_BEQ, OP_BNE: next = BRANCH;
          OP_J:           next = JUMP;
          default:        il = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op = opcode == OP_LW ? 3'b010 : 3'b011;
        next = opcode == OP_LW ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        i_or_d = 1'b1;
        mem_read = 1'b1;
        next = rdy ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        rw = 1'b1;
        dn = 1'b1;
      end
      MEM_WR: begin
        i_or_d = 1'b1;
        mw = 1'b1;
        dn = rdy;
        next = rdy ? FETCH : MEM_WR;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op = 3'b111;
        next = R_WB;
      end
      R_WB: begin
        reg_dst = 1'b1;
        rw = 1'b1;
        dn = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op = opcode == OP_ORI ? 3'b101 : 3'b100;
        next = I_WB;
      end
      I_WB: begin
        rw = 1'b1;
        dn = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = 3'b001;
        pc_source = 2'b01;
        pw = opcode == OP_BNE ? ~zero : zero;
        dn = 1'b1;
      end
      JUMP: begin
        pc_source = 2'b10;
        pw = 1'b1;
        dn = 1'b1;
      end
      default: next = FETCH;
    endcase
  end
  // an aborted instruction must commit nothing while reset is held low
  assign mem_write = mw & reset;
  assign ir_write = iw & reset;
  assign pc_write = pw & reset;
  assign reg_write = rw & reset;
  assign instr_done = dn & reset;
  assign illegal_op = il & reset;
  assign state_o = state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table-driven per-cycle checks of the multicycle control FSM
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0, reset = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [3:0] state_o, s0;
  logic [2:0] alu_op, a0;
  logic [1:0] alu_src_b, pc_source, b0, p0;
  logic alu_src_a, i_or_d, mem_read, mem_write, ir_write, pc_write, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;
  logic x_a, x_d, x_r, x_w, x_i, x_p, x_rd, x_mr, x_rw, x_dn, x_il;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state_o(state_o), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .instr_done(instr_done), .illegal_op(illegal_op)
  );
  mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state_o(s0), .alu_op(a0), .alu_src_a(x_a), .alu_src_b(b0),
    .i_or_d(x_d), .mem_read(x_r), .mem_write(x_w), .ir_write(x_i),
    .pc_write(x_p), .pc_source(p0), .reg_dst(x_rd), .mem_to_reg(x_mr),
    .reg_write(x_rw), .instr_done(x_dn), .illegal_op(x_il)
  );
  typedef struct {
    logic rst; logic [5:0] op; logic z; logic rdy;
    logic [3:0] st; logic [2:0] aop; logic [1:0] srcb; logic [1:0] psrc; logic [10:0] fl;
  } vec_t;
  vec_t tv[$];
  // flag order: src_a i_or_d mem_read mem_write ir_write pc_write reg_dst mem_to_reg reg_write instr_done illegal_op
  localparam logic [10:0] FN = 11'b00100000000, FR = 11'b00101100000, NO = 11'b00000000000,
    ILL = 11'b00000000001, A = 11'b10000000000, MRD = 11'b01100000000, MWB = 11'b00000001110,
    MWN = 11'b01010000000, MWX = 11'b01000000000, RWB = 11'b00000010110, IWB = 11'b00000000110,
    BR1 = 11'b10000100010, BR0 = 11'b10000000010, JMP = 11'b00000100010;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic [5:0] o, input logic z, input logic m,
                     input logic [3:0] s, input logic [2:0] a, input logic [1:0] b,
                     input logic [1:0] p, input logic [10:0] f);
    tv.push_back('{r, o, z, m, s, a, b, p, f});
  endtask
  task automatic fd(input logic [5:0] o, input logic z);
    add(1'b1, o, z, 1'b1, 4'd0, 3'b100, 2'b01, 2'b00, FR);
    add(1'b1, o, z, 1'b1, 4'd1, 3'b100, 2'b11, 2'b00, NO);
  endtask
  initial begin
    int n;
    for (int k = 0; k < 3; k++) add(1'b0, 6'd0, 1'b0, 1'b1, 4'd0, 3'b100, 2'b01, 2'b00, FN);
    fd(6'b000000, 1'b0);
    add(1'b1, 6'b000000, 1'b0, 1'b1, 4'd6, 3'b111, 2'b00, 2'b00, A);
    add(1'b1, 6'b000000, 1'b0, 1'b1, 4'd7, 3'b000, 2'b00, 2'b00, RWB);
    fd(6'b100011, 1'b0);
    add(1'b1, 6'b100011, 1'b0, 1'b1, 4'd2, 3'b010, 2'b10, 2'b00, A);
    add(1'b1, 6'b100011, 1'b0, 1'b0, 4'd3, 3'b000, 2'b00, 2'b00, MRD);
    add(1'b1, 6'b100011, 1'b0, 1'b0, 4'd3, 3'b000, 2'b00, 2'b00, MRD);
    add(1'b1, 6'b100011, 1'b0, 1'b1, 4'd3, 3'b000, 2'b00, 2'b00, MRD);
    add(1'b1, 6'b100011, 1'b0, 1'b1, 4'd4, 3'b000, 2'b00, 2'b00, MWB);
    fd(6'b000101, 1'b1);
    add(1'b1, 6'b000101, 1'b1, 1'b1, 4'd10, 3'b001, 2'b00, 2'b01, BR0);
    fd(6'b000101, 1'b0);
    add(1'b1, 6'b000101, 1'b0, 1'b1, 4'd10, 3'b001, 2'b00, 2'b01, BR1);
    fd(6'b000100, 1'b1);
    add(1'b1, 6'b000100, 1'b1, 1'b1, 4'd10, 3'b001, 2'b00, 2'b01, BR1);
    fd(6'b000100, 1'b0);
    add(1'b1, 6'b000100, 1'b0, 1'b1, 4'd10, 3'b001, 2'b00, 2'b01, BR0);
    add(1'b1, 6'b111111, 1'b0, 1'b1, 4'd0, 3'b100, 2'b01, 2'b00, FR);
    add(1'b1, 6'b111111, 1'b0, 1'b1, 4'd1, 3'b100, 2'b11, 2'b00, ILL);
    add(1'b1, 6'b000010, 1'b0, 1'b0, 4'd0, 3'b100, 2'b01, 2'b00, FN);
    fd(6'b000010, 1'b0);
    add(1'b1, 6'b000010, 1'b0, 1'b1, 4'd11, 3'b000, 2'b00, 2'b10, JMP);
    fd(6'b101011, 1'b0);
    add(1'b1, 6'b101011, 1'b0, 1'b1, 4'd2, 3'b011, 2'b10, 2'b00, A);
    add(1'b1, 6'b101011, 1'b0, 1'b0, 4'd5, 3'b000, 2'b00, 2'b00, MWN);
    add(1'b0, 6'b101011, 1'b0, 1'b1, 4'd5, 3'b000, 2'b00, 2'b00, MWX);
    fd(6'b001101, 1'b0);
    add(1'b1, 6'b001101, 1'b0, 1'b1, 4'd8, 3'b101, 2'b10, 2'b00, A);
    add(1'b1, 6'b001101, 1'b0, 1'b1, 4'd9, 3'b000, 2'b00, 2'b00, IWB);
    fd(6'b001000, 1'b0);
    add(1'b1, 6'b001000, 1'b0, 1'b1, 4'd8, 3'b100, 2'b10, 2'b00, A);
    add(1'b1, 6'b001000, 1'b0, 1'b1, 4'd9, 3'b000, 2'b00, 2'b00, IWB);
    add(1'b1, 6'b000000, 1'b0, 1'b1, 4'd0, 3'b100, 2'b01, 2'b00, FR);
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      reset = tv[i].rst; opcode = tv[i].op; zero = tv[i].z; mem_ready = tv[i].rdy;
      #1;
      chk($sformatf("vec%0d", i),
          {10'd0, state_o, alu_op, alu_src_b, pc_source, alu_src_a, i_or_d, mem_read, mem_write,
           ir_write, pc_write, reg_dst, mem_to_reg, reg_write, instr_done, illegal_op},
          {10'd0, tv[i].st, tv[i].aop, tv[i].srcb, tv[i].psrc, tv[i].fl});
    end
    // with memory waits disabled, LW must finish in 5 cycles even though mem_ready stays low
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; opcode = 6'b100011; mem_ready = 1'b0;
    #1;
    chk("nowait_ir_write", {31'd0, x_i}, 32'd1);
    n = 1;
    while (!x_dn && n <= 12) begin
      @(negedge clk); #1;
      n++;
    end
    chk("nowait_lw_cycles", n, 32'd5);
    chk("wait_fetch_stall", {28'd0, state_o}, 32'd0);
    chk("wait_no_ir_write", {31'd0, ir_write}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control state machine for the multicycle MIPS core. It sequences the shared ALU, memory port, IR, PC and register file across fetch, decode, execute, memory and writeback cycles. It drives the 3-bit alu_op code consumed by the ALU control decoder, using the R-type/ADDI/ORI/LW/SW/branch encodings listed under Behaviour. It sits between the instruction register opcode field and the datapath muxes and write enables.

Parameters:
MEM_WAIT_EN, 1, 1: memory states stall until mem_ready=1; 0: mem_ready is ignored and treated as 1.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
opcode  in  6  IR[31:26]; valid from DECODE onward
zero  in  1  ALU zero flag, used in BRANCH
mem_ready  in  1  memory access completes this cycle
state_o  out  4  current state encoding, for debug and verification
alu_op  out  3  to ALU control decoder
alu_src_a  out  1  0=PC, 1=register A
alu_src_b  out  2  00=B, 01=const 4, 10=sign-extended imm, 11=imm<<2
i_or_d  out  1  0=PC address, 1=ALUOut address
mem_read  out  1  memory read enable
mem_write  out  1  memory write enable
ir_write  out  1  IR load enable
pc_write  out  1  PC load enable
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
reg_write  out  1  register file write enable
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode

Behaviour:
- State register only. All outputs are decoded combinationally from the state; opcode, zero and mem_ready qualify outputs only where stated below.
- Any output not listed for a state is 0, and alu_op defaults to 3'b000.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11. Codes 12-15 are unreachable and go to FETCH.
- Reset: when reset=0 at a rising edge, the state becomes FETCH. While reset=0, mem_write, reg_write, pc_write, ir_write, instr_done and illegal_op are forced to 0, so an instruction aborted mid-operation commits nothing.
- FETCH: mem_read=1, alu_src_b=01, alu_op=100. ir_write and pc_write equal rdy, where rdy = mem_ready, or 1 when MEN_WAIT_EN=0. Stay in FETCH while rdy=0; go to DECODE when rdy=1.
- DECODE: alu_src_b=11, alu_op=100 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC_R
  - 001000 (ADDI), 001101 (ORI) -> EXEC_I
  - 100011 (LW), 101011 (SW) -> MEM_ADDR
  - 000100 (BEQ), 000101 (BNE) -> BRANCH
  - 000010 (J) -> JUMP
  - any other opcode -> FETCH with illegal_op=1
- MEM_ADDR: alu_src_a=1, alu_src_b=10. alu_op=010 for LW, 011 for SW. LW goes to MEM_RD, SW goes to MEM_WR.
- MEM_RD: i_or_d=1, mem_read=1. Hold while rdy=0, then go to MEM_WB.
- MEM_WB: mem_to_reg=1, reg_write=1, instr_done=1. Go to FETCH.
- MEM_WR: i_or_d=1, mem_write=1. Hold while rdy=0. On rdy=1, instr_done=1 and go to FETCH.
- EXEC_R: alu_src_a=1, alu_op=111. Go to R_WB.
- R_WB: reg_dst=1, reg_write=1, instr_done=1. Go to FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10. alu_op=100 for ADDI, 101 for ORI. Go to I_WB.
- I_WB: reg_write=1, instr_done=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_op=001, pc_source=01, instr_done=1. pc_write = zero for BEQ, ~zero for BNE. Go to FETCH.
- JUMP: pc_source=10, pc_write=1, instr_done=1. Go to FETCH.
- Latency with rdy always 1: LW 5, SW 4, R-type 4, ADDI/ORI 4, BEQ/BNE 3, J 3 cycles.
- mem_write and reg_write are never both 1 in the same cycle.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> state_o=0, mem_read=1, all write enables 0 during reset.
- R-type, opcode 000000, mem_ready=1 -> states 0,1,6,7; alu_op=111 in EXEC_R; in R_WB reg_dst=1, reg_write=1, instr_done=1.
- LW with mem_ready low for 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4; alu_op=010 in MEM_ADDR; mem_to_reg=1 in MEM_WB; total 7 cycles.
- BNE, opcode 000101: zero=1 gives pc_write=0 in BRANCH; zero=0 gives pc_write=1 with pc_source=01; BEQ gives the inverse.
- Opcode 111111 -> illegal_op pulses in DECODE, next state FETCH, no reg_write or mem_write.
- SW with reset driven low in MEM_WR -> mem_write=0 that cycle, state_o=0 next cycle; ORI afterwards completes with alu_op=101.
